stopwatch_ctrl: RTL and testbench

Run/pause/lap/clear sequencer for the two-digit BCD seconds counter of the stopwatch.
- Divides the system clock into a one-cycle count tick and gates it to the counter's count input.
- Drives the counter's enable switch and issues a counter clear.
- Freezes a lap snapshot of the seconds value for the display path while counting continues.
- Sits between the debounced one-pulse button logic and the seconds counter / 7-segment mux.

---
 rtl/stopwatch_ctrl.sv | 120 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer for a two-digit BCD seconds counter.
// Generates the gated count tick, counter enable/clear and the lap-frozen display.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned CNT_W    = 27,
  parameter int unsigned BCD_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_stop,
  input  logic             lap_reset,
  input  logic [BCD_W-1:0] sec1_in,
  input  logic [BCD_W-1:0] sec0_in,
  output logic             count_out,
  output logic             switch_out,
  output logic             cnt_rst_n,
  output logic [BCD_W-1:0] disp1,
  output logic [BCD_W-1:0] disp0,
  output logic             lap_led,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StLap   = 2'b10,
    StPause = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] PrescMax = CNT_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             switch_q, switch_d;
  logic             cnt_rst_n_q, cnt_rst_n_d;
  logic             lap_led_q, lap_led_d;
  logic [BCD_W-1:0] lap1_q, lap1_d;
  logic [BCD_W-1:0] lap0_q, lap0_d;

  logic counting;
  logic tick;

  assign counting = (state_q == StRun) || (state_q == StLap);
  assign tick     = counting && (presc_q == PrescMax);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    lap1_d      = lap1_q;
    lap0_d      = lap0_q;
    cnt_rst_n_d = 1'b1;

    // start_stop is tested first everywhere so it wins over a coincident lap_reset.
    unique case (state_q)
      StIdle: begin
        if (start_stop) state_d = StRun;
      end
      StRun: begin
        if (start_stop) begin
          state_d = StPause;
        end else if (lap_reset) begin
          state_d = StLap;
          lap1_d  = sec1_in;
          lap0_d  = sec0_in;
        end
      end
      StLap: begin
        if (start_stop)     state_d = StPause;
        else if (lap_reset) state_d = StRun;
      end
      StPause: begin
        if (start_stop) begin
          state_d = StRun;
        end else if (lap_reset) begin
          state_d     = StIdle;
          cnt_rst_n_d = 1'b0;
        end
      end
    endcase

    // Prescaler advances on the current state, so PAUSE keeps a partial second.
    if (counting) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end else if (state_d == StIdle) begin
      presc_d = '0;
    end

    switch_d  = (state_d == StRun) || (state_d == StLap);
    lap_led_d = (state_d == StLap);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      switch_q    <= 1'b0;
      cnt_rst_n_q <= 1'b0;
      lap_led_q   <= 1'b0;
      lap1_q      <= '0;
      lap0_q      <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      switch_q    <= switch_d;
      cnt_rst_n_q <= cnt_rst_n_d;
      lap_led_q   <= lap_led_d;
      lap1_q      <= lap1_d;
      lap0_q      <= lap0_d;
    end
  end

  assign count_out  = tick;
  assign switch_out = switch_q;
  assign cnt_rst_n  = cnt_rst_n_q;
  assign lap_led    = lap_led_q;
  assign state      = state_q;
  assign disp1      = (state_q == StLap) ? lap1_q : sec1_in;
  assign disp0      = (state_q == StLap) ? lap0_q : sec0_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed table-driven bench for stopwatch_ctrl with TICK_DIV = 4.
// Each vector holds inputs across one rising edge; outputs are checked 1 time unit later.
module tb_stopwatch_ctrl;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned CntW    = 3;
  localparam int unsigned BcdW    = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_stop = 1'b0;
  logic            lap_reset = 1'b0;
  logic [BcdW-1:0] sec1_in = '0;
  logic [BcdW-1:0] sec0_in = '0;
  logic            count_out;
  logic            switch_out;
  logic            cnt_rst_n;
  logic [BcdW-1:0] disp1;
  logic [BcdW-1:0] disp0;
  logic            lap_led;
  logic [1:0]      state;

  stopwatch_ctrl #(
    .TICK_DIV (TickDiv),
    .CNT_W    (CntW),
    .BCD_W    (BcdW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .lap_reset  (lap_reset),
    .sec1_in    (sec1_in),
    .sec0_in    (sec0_in),
    .count_out  (count_out),
    .switch_out (switch_out),
    .cnt_rst_n  (cnt_rst_n),
    .disp1      (disp1),
    .disp0      (disp0),
    .lap_led    (lap_led),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ss;
    logic       lr;
    logic [3:0] s1;
    logic [3:0] s0;
    logic [1:0] st;
    logic       co;
    logic       rn;
    logic [3:0] d1;
    logic [3:0] d0;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Expected switch_out and lap_led follow directly from the expected state.
  task automatic check_outs(input int idx, input logic [1:0] st, input logic co,
                            input logic rn, input logic [3:0] d1, input logic [3:0] d0);
    chk("state", idx, 32'(state), 32'(st));
    chk("switch_out", idx, 32'(switch_out), 32'((st == 2'b01) || (st == 2'b10)));
    chk("count_out", idx, 32'(count_out), 32'(co));
    chk("cnt_rst_n", idx, 32'(cnt_rst_n), 32'(rn));
    chk("lap_led", idx, 32'(lap_led), 32'(st == 2'b10));
    chk("disp1", idx, 32'(disp1), 32'(d1));
    chk("disp0", idx, 32'(disp0), 32'(d0));
  endtask

  task automatic add(input logic ss, input logic lr, input logic [3:0] s1, input logic [3:0] s0,
                     input logic [1:0] st, input logic co, input logic rn,
                     input logic [3:0] d1, input logic [3:0] d0);
    vec_t v;
    v.ss = ss; v.lr = lr; v.s1 = s1; v.s0 = s0;
    v.st = st; v.co = co; v.rn = rn; v.d1 = d1; v.d0 = d0;
    vecs.push_back(v);
  endtask

  initial begin
    // Idle, lap_reset ignored in IDLE, then start: ticks on cycles 4, 8, 12.
    add(0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
    add(0, 1, 0, 0, 2'b00, 0, 1, 0, 0);
    add(1, 0, 0, 0, 2'b01, 0, 1, 0, 0);
    for (int k = 1; k <= 12; k++) add(0, 0, 0, 0, 2'b01, (k % 4) == 3, 1, 0, 0);
    // Lap at 07 while the counter advances to 09; tick still passes in LAP.
    add(0, 1, 0, 7, 2'b10, 0, 1, 0, 7);
    add(0, 0, 0, 8, 2'b10, 0, 1, 0, 7);
    add(0, 0, 0, 8, 2'b10, 1, 1, 0, 7);
    add(0, 0, 0, 9, 2'b10, 0, 1, 0, 7);
    add(0, 1, 0, 9, 2'b01, 0, 1, 0, 9);
    // Pause with prescaler at 2, 20 quiet cycles, resume ticks at once.
    add(0, 0, 0, 9, 2'b01, 0, 1, 0, 9);
    add(1, 0, 0, 9, 2'b11, 0, 1, 0, 9);
    for (int k = 0; k < 20; k++) add(0, 0, 0, 9, 2'b11, 0, 1, 0, 9);
    add(1, 0, 0, 9, 2'b01, 1, 1, 0, 9);
    add(0, 0, 1, 0, 2'b01, 0, 1, 1, 0);
    // Simultaneous pulses in RUN: PAUSE, no lap, no clear.
    add(1, 1, 1, 0, 2'b11, 0, 1, 1, 0);
    // Clear from PAUSE: one-cycle cnt_rst_n, then a fresh 4-cycle first tick.
    add(0, 1, 1, 0, 2'b00, 0, 0, 1, 0);
    add(0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
    add(1, 0, 0, 0, 2'b01, 0, 1, 0, 0);
    add(0, 0, 0, 0, 2'b01, 0, 1, 0, 0);
    add(0, 0, 0, 0, 2'b01, 0, 1, 0, 0);
    add(0, 0, 0, 0, 2'b01, 1, 1, 0, 0);
    // LAP -> PAUSE goes live; resume, lap again and stay frozen.
    add(0, 1, 3, 4, 2'b10, 0, 1, 3, 4);
    add(1, 0, 3, 5, 2'b11, 0, 1, 3, 5);
    add(1, 0, 3, 5, 2'b01, 0, 1, 3, 5);
    add(0, 1, 4, 2, 2'b10, 0, 1, 4, 2);
    add(0, 0, 4, 3, 2'b10, 1, 1, 4, 2);

    // Reset values while rst is held.
    #12;
    check_outs(-1, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("cnt_rst_n before first edge", -1, 32'(cnt_rst_n), 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      start_stop = vecs[i].ss;
      lap_reset  = vecs[i].lr;
      sec1_in    = vecs[i].s1;
      sec0_in    = vecs[i].s0;
      @(posedge clk);
      #1;
      check_outs(i, vecs[i].st, vecs[i].co, vecs[i].rn, vecs[i].d1, vecs[i].d0);
    end

    // Asynchronous reset mid-LAP, between edges, while a tick is showing.
    @(negedge clk);
    start_stop = 1'b0;
    lap_reset  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_outs(100, 2'b00, 0, 0, 4, 3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("cnt_rst_n after rst release", 101, 32'(cnt_rst_n), 32'd0);
    @(posedge clk);
    #1;
    check_outs(102, 2'b00, 0, 1, 4, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
